// File: rtl/slot_pool_pkg.sv
// slot_pool_pkg: shared slot_pool widths, id/count types and one-hot to id conversion
package slot_pool_pkg;
  localparam int W_DEF = 32;
  localparam int IDW_DEF = $clog2(W_DEF);
  typedef logic [IDW_DEF-1:0] id_t;
  typedef logic [IDW_DEF:0] cnt_t;
  function automatic id_t oh2id(input logic [W_DEF-1:0] oh);
    id_t id;
    id = '0;
    for (int i = 0; i < W_DEF; i++) id |= oh[i] ? id_t'(i) : id_t'(0);
    return id;
  endfunction
endpackage

// File: rtl/slot_pool_find.sv
// slot_pool_find: circular first-zero search downward from pos-1, bit pos examined last
module slot_pool_find
  import slot_pool_pkg::*;
#(
  parameter int W = W_DEF,
  localparam int IDW = $clog2(W)
) (
  input  logic [W-1:0]   vec,
  input  logic [IDW-1:0] pos,
  output logic [W-1:0]   oh,
  output logic [IDW-1:0] id,
  output logic           any
);
  logic [W-1:0] r, z, roh;
  logic [W_DEF-1:0] ohx;
  assign r = W'({vec, vec} >> pos);
  assign z = ~r;
  always_comb begin
    roh = '0;
    for (int i = 0; i < W; i++) roh = z[i] ? W'(1) << i : roh;
  end
  assign oh = W'(({roh, roh} << pos) >> W);
  always_comb begin
    ohx = '0;
    ohx[W-1:0] = oh;
  end
  assign id = IDW'(oh2id(ohx));
  assign any = |z;
endmodule

// File: rtl/slot_pool.sv
// slot_pool: circular slot allocator with occupancy/count/status; SLOT_POOL_FREE_BYPASS_EN makes a freed slot grantable the same cycle
module slot_pool
  import slot_pool_pkg::*;
#(
  parameter int W = W_DEF,
  localparam int IDW = $clog2(W)
) (
  input  logic           clk,
  input  logic           arst,
  input  logic           alloc_req_i,
  output logic           alloc_gnt_o,
  output logic [IDW-1:0] alloc_id_o,
  input  logic           free_vld_i,
  input  logic [IDW-1:0] free_id_i,
  output logic [W-1:0]   occ_o,
  output logic [IDW:0]   count_o,
  output logic           full_o,
  output logic           empty_o,
  output logic           free_err_o
);
  typedef logic [IDW:0] cw_t;
  logic [W-1:0] occ, free_oh, search, cand_oh;
  logic [IDW-1:0] ptr, cand_id;
  cw_t count;
  logic legal, any, err;
  assign legal = free_vld_i & occ[free_id_i];
  assign free_oh = W'(legal) << free_id_i;
`ifdef SLOT_POOL_FREE_BYPASS_EN
  assign search = occ & ~free_oh;
`else
  assign search = occ;
`endif
  slot_pool_find #(.W(W)) u_find (
    .vec(search),
    .pos(ptr),
    .oh (cand_oh),
    .id (cand_id),
    .any(any)
  );
  assign alloc_gnt_o = alloc_req_i & any;
  assign alloc_id_o = cand_id;
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      occ <= '0;
      ptr <= '0;
      count <= '0;
      err <= 1'b0;
    end else begin
      occ <= (occ & ~free_oh) | (alloc_gnt_o ? cand_oh : '0);
      ptr <= alloc_gnt_o ? cand_id : ptr;
      count <= count + cw_t'(alloc_gnt_o) - cw_t'(legal);
      err <= err | (free_vld_i & ~occ[free_id_i]);
    end
  assign occ_o = occ;
  assign count_o = count;
  assign full_o = count == cw_t'(W);
  assign empty_o = count == '0;
  assign free_err_o = err;
endmodule

// File: tb/tb_slot_pool.sv
// tb_slot_pool: vector table, corner sequences and randomized reference-model check of slot_pool (W=8)
module tb_slot_pool;
  localparam int W = 8;
  logic clk = 0, arst = 0, alloc_req_i = 0, free_vld_i = 0;
  logic [2:0] free_id_i = 0;
  logic alloc_gnt_o, full_o, empty_o, free_err_o;
  logic [2:0] alloc_id_o;
  logic [7:0] occ_o;
  logic [3:0] count_o;
  int total = 0, passed = 0;

  slot_pool #(.W(W)) dut (
    .clk        (clk),
    .arst       (arst),
    .alloc_req_i(alloc_req_i),
    .alloc_gnt_o(alloc_gnt_o),
    .alloc_id_o (alloc_id_o),
    .free_vld_i (free_vld_i),
    .free_id_i  (free_id_i),
    .occ_o      (occ_o),
    .count_o    (count_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .free_err_o (free_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic req;
    logic fv;
    logic [2:0] fid;
    logic gnt;
    logic chk_id;
    logic [2:0] id;
    int cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic req, logic fv, logic [2:0] fid, logic gnt, logic chk_id, logic [2:0] id, int cnt);
    vec_t v;
    v.req = req;
    v.fv = fv;
    v.fid = fid;
    v.gnt = gnt;
    v.chk_id = chk_id;
    v.id = id;
    v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cyc(input logic r, input logic fv, input logic [2:0] fid, output logic g, output logic [2:0] id);
    alloc_req_i = r;
    free_vld_i = fv;
    free_id_i = fid;
    #1;
    g = alloc_gnt_o;
    id = alloc_id_o;
    @(posedge clk);
    #1;
    alloc_req_i = 0;
    free_vld_i = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    arst = 1;
    #2;
    arst = 0;
    @(negedge clk);
  endtask

  logic g;
  logic [2:0] id;
  bit [7:0] occ_m;
  int ptr_m, cnt_m, cand, fid_r, k;
  bit found, r, fv, legal;
  bit [7:0] sv;

  initial begin
    #1 arst = 1;
    #2;
    chk("reset_occ", occ_o, 0);
    chk("reset_count", count_o, 0);
    chk("reset_full", full_o, 0);
    chk("reset_empty", empty_o, 1);
    chk("reset_err", free_err_o, 0);
    @(negedge clk);
    arst = 0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) add(1, 0, 0, 1, 1, 3'(7 - i), i + 1);
    add(1, 0, 0, 0, 0, 0, 8);
`ifdef SLOT_POOL_FREE_BYPASS_EN
    add(1, 1, 5, 1, 1, 5, 8);
    add(1, 0, 0, 0, 0, 0, 8);
`else
    add(1, 1, 5, 0, 0, 0, 7);
    add(1, 0, 0, 1, 1, 5, 8);
`endif
    add(0, 1, 3, 0, 0, 0, 7);
    add(1, 0, 0, 1, 1, 3, 8);
    add(0, 1, 1, 0, 0, 0, 7);
    add(0, 1, 3, 0, 0, 0, 6);
    add(1, 0, 0, 1, 1, 1, 7);
    add(1, 0, 0, 1, 1, 3, 8);
    foreach (tbl[i]) begin
      cyc(tbl[i].req, tbl[i].fv, tbl[i].fid, g, id);
      chk($sformatf("v%0d_gnt", i), g, tbl[i].gnt);
      if (tbl[i].chk_id) chk($sformatf("v%0d_id", i), id, tbl[i].id);
      chk($sformatf("v%0d_count", i), count_o, tbl[i].cnt);
      chk($sformatf("v%0d_full", i), full_o, tbl[i].cnt == 8);
      chk($sformatf("v%0d_empty", i), empty_o, tbl[i].cnt == 0);
      chk($sformatf("v%0d_err", i), free_err_o, 0);
    end
    chk("tbl_occ", occ_o, 8'hFF);

    do_reset();
    cyc(0, 1, 2, g, id);
    chk("badfree_err", free_err_o, 1);
    chk("badfree_count", count_o, 0);
    chk("badfree_empty", empty_o, 1);
    chk("badfree_occ", occ_o, 0);
    cyc(1, 0, 0, g, id);
    chk("badfree_sticky", free_err_o, 1);
    chk("after_err_gnt", g, 1);
    chk("after_err_id", id, 7);
    do_reset();
    chk("err_cleared", free_err_o, 0);

    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, g, id);
      chk("pre_rst_id", id, 7 - i);
    end
    chk("pre_rst_count", count_o, 3);
    #2 arst = 1;
    #1;
    chk("midrst_occ", occ_o, 0);
    chk("midrst_count", count_o, 0);
    chk("midrst_empty", empty_o, 1);
    arst = 0;
    @(negedge clk);
    cyc(1, 0, 0, g, id);
    chk("post_rst_gnt", g, 1);
    chk("post_rst_id", id, 7);

    do_reset();
    occ_m = '0;
    ptr_m = 0;
    cnt_m = 0;
    for (int c = 0; c < 10000; c++) begin
      r = $urandom_range(0, 9) < 6;
      fv = 0;
      fid_r = $urandom_range(0, 7);
      if (cnt_m > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, cnt_m - 1);
        for (int j = 0; j < 8; j++)
          if (occ_m[j]) begin
            if (k == 0) begin
              fid_r = j;
              fv = 1;
            end
            k--;
          end
      end
      legal = fv && occ_m[fid_r];
      sv = occ_m;
`ifdef SLOT_POOL_FREE_BYPASS_EN
      if (legal) sv[fid_r] = 0;
`endif
      found = 0;
      cand = 0;
      for (int j = 1; j <= 8; j++)
        if (!found && !sv[(ptr_m - j + 8) % 8]) begin
          cand = (ptr_m - j + 8) % 8;
          found = 1;
        end
      cyc(r, fv, 3'(fid_r), g, id);
      chk("rnd_gnt", g, r && found);
      if (r && found) chk("rnd_id", id, cand);
      if (legal) begin
        occ_m[fid_r] = 0;
        cnt_m--;
      end
      if (r && found) begin
        occ_m[cand] = 1;
        cnt_m++;
        ptr_m = cand;
      end
      chk("rnd_occ", occ_o, occ_m);
      chk("rnd_count", count_o, cnt_m);
      chk("rnd_popcount", count_o, $countones(occ_o));
      chk("rnd_full", full_o, cnt_m == 8);
      chk("rnd_err", free_err_o, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
